// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed seven-segment driver.
//   SEG_BLANK    : all segments off (active-low)
//   SEG_HEX      : hex nibble -> active-low segments, bit7 = dp (off), bits6..0 = g..a
//   scan_state_e : scan FSM states
package seg_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Entry 15 first so that SEG_HEX[n] is the pattern for nibble n.
    localparam logic [15:0][7:0] SEG_HEX = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    typedef enum logic {
        DRIVE = 1'b0,
        BLANK = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-seven-segment decoder, active-low outputs.
//   nibble_i : hex digit 0..F
//   dp_i     : decimal point request, 1 = lit
//   seg_o    : {~dp, g..a}
module hex7seg_dec
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);

    assign seg_o = {~dp_i, SEG_HEX[nibble_i][6:0]};

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed N-digit common-anode seven-segment driver.
// Each digit is driven for SCAN_DIV+1 cycles followed by BLANK_CYC all-off
// cycles. Loaded values wait in a shadow register and become active only at
// the frame boundary, so a frame never mixes old and new digits.
//   clk_i/rst_i    : clock, synchronous active-high reset
//   value_i        : one hex nibble per digit, digit 0 rightmost
//   dp_i           : per-digit decimal point, 1 = lit
//   lzb_en_i       : leading-zero blanking, captured with value_i
//   load_i         : one-cycle capture pulse
//   sel_o          : one-hot digit enable, active-high
//   seg_o          : segments, active-low, bit7 = dp
//   frame_done_o   : pulse when digit 0 of a new frame appears on sel_o
//   pending_o      : a captured load is waiting for the frame boundary
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIGITS    = 6,
    parameter int SCAN_DIV  = 49_999,
    parameter int BLANK_CYC = 500
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [DIGITS-1:0][3:0] value_i,
    input  logic [DIGITS-1:0]      dp_i,
    input  logic                   lzb_en_i,
    input  logic                   load_i,
    output logic [DIGITS-1:0]      sel_o,
    output logic [7:0]             seg_o,
    output logic                   frame_done_o,
    output logic                   pending_o
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CW      = ($clog2(CNT_MAX + 1) < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam int IW      = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [CW-1:0] SCAN_LAST  = CW'(SCAN_DIV);
    localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0] IDX_LAST   = IW'(DIGITS - 1);

    scan_state_e              state_q;
    logic [CW-1:0]            cnt_q;
    logic [IW-1:0]            idx_q, idx_d;
    logic                     wrap_q;
    logic                     fd_q;
    logic                     pending_q;
    logic [DIGITS-1:0][3:0]   sh_val_q, act_val_q;
    logic [DIGITS-1:0]        sh_dp_q, act_dp_q;
    logic                     sh_lzb_q, act_lzb_q;
    logic [DIGITS-1:0]        sel_q, sel_d;
    logic [7:0]               seg_q, seg_d;

    logic                     adv, wrap;
    logic [DIGITS-1:0]        lzb_blank;
    logic [3:0]               cur_nib;
    logic                     cur_dp, cur_blank;
    logic [7:0]               dec_seg;

    // Digit advance: end of the blank slot, or end of the drive slot when
    // there is no blank slot.
    always_comb begin
        adv = 1'b0;
        if (state_q == DRIVE) adv = (cnt_q == SCAN_LAST) && (BLANK_CYC == 0);
        else                  adv = (cnt_q == BLANK_LAST);
    end

    assign wrap  = adv && (idx_q == IDX_LAST);
    assign idx_d = wrap ? '0 : (adv ? idx_q + 1'b1 : idx_q);

    // A digit blanks only while every higher digit has blanked too; digit 0
    // is never in the chain.
    always_comb begin
        logic run;
        run       = act_lzb_q;
        lzb_blank = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run          = run && (act_val_q[i] == 4'h0) && !act_dp_q[i];
            lzb_blank[i] = run;
        end
    end

    // Current-digit mux and one-hot select, written as a compare loop so
    // non-power-of-two DIGITS never indexes past the arrays.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        sel_d     = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nib   = act_val_q[i];
                cur_dp    = act_dp_q[i];
                cur_blank = lzb_blank[i];
                sel_d[i]  = (state_q == DRIVE);
            end
        end
    end

    hex7seg_dec u_dec (
        .nibble_i (cur_nib),
        .dp_i     (cur_dp),
        .seg_o    (dec_seg)
    );

    assign seg_d = ((state_q == DRIVE) && !cur_blank) ? dec_seg : SEG_BLANK;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= DRIVE;
            cnt_q     <= '0;
            idx_q     <= '0;
            wrap_q    <= 1'b0;
            fd_q      <= 1'b0;
            pending_q <= 1'b0;
            sh_val_q  <= '0;
            sh_dp_q   <= '0;
            sh_lzb_q  <= 1'b0;
            act_val_q <= '0;
            act_dp_q  <= '0;
            act_lzb_q <= 1'b0;
            sel_q     <= '0;
            seg_q     <= SEG_BLANK;
        end else begin
            case (state_q)
                DRIVE: begin
                    if (cnt_q == SCAN_LAST) begin
                        cnt_q <= '0;
                        if (BLANK_CYC != 0) state_q <= BLANK;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_q   <= '0;
                        state_q <= DRIVE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= DRIVE;
            endcase

            idx_q <= idx_d;

            // Outputs trail the index by a cycle, so the boundary marker is
            // delayed once more to land with digit 0 on sel.
            wrap_q <= wrap;
            fd_q   <= wrap_q;

            if (wrap) begin
                pending_q <= 1'b0;
                if (load_i) begin
                    act_val_q <= value_i;
                    act_dp_q  <= dp_i;
                    act_lzb_q <= lzb_en_i;
                end else if (pending_q) begin
                    act_val_q <= sh_val_q;
                    act_dp_q  <= sh_dp_q;
                    act_lzb_q <= sh_lzb_q;
                end
            end else if (load_i) begin
                sh_val_q  <= value_i;
                sh_dp_q   <= dp_i;
                sh_lzb_q  <= lzb_en_i;
                pending_q <= 1'b1;
            end

            sel_q <= sel_d;
            seg_q <= seg_d;
        end
    end

    assign sel_o        = sel_q;
    assign seg_o        = seg_q;
    assign frame_done_o = fd_q;
    assign pending_o    = pending_q;

endmodule
